mem_arbiter: RTL and testbench

- Shares the single pipelined main memory between the I-cache fill FSM and the D-cache (fill FSM plus write-through stores).
- Selects one requester and sequences a complete transaction:
  - an 8-word block fill, issuing word addresses itself and routing returning data to the winner; or
  - a single-word store.
- The owning fill FSM holds off and stalls the pipeline until it sees its done pulse.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache fill
// engine and the D-cache (block fills plus single-word write-through stores).
// A fill issues WORDS consecutive word addresses and counts returning valids,
// so the arbiter never depends on the memory's read latency.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic              i_done,
  output logic              d_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS);
  localparam int ISS_W = CNT_W + 1;

  // Issue counter needs one extra bit to represent "all words issued".
  localparam logic [ISS_W-1:0]  ISS_ALL   = ISS_W'(WORDS);
  localparam logic [CNT_W-1:0]  RSP_LAST  = CNT_W'(WORDS - 1);
  // Clears the byte-in-block bits (2-byte words, WORDS per block).
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(2 * WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_I_FILL,
    S_D_FILL,
    S_D_WRITE
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state_q,      state_d;
  owner_t            last_owner_q, last_owner_d;
  logic [ISS_W-1:0]  issue_cnt_q,  issue_cnt_d;
  logic [CNT_W-1:0]  rsp_cnt_q,    rsp_cnt_d;
  logic [ADDR_W-1:0] base_q,       base_d;
  logic [ADDR_W-1:0] st_addr_q,    st_addr_d;
  logic [DATA_W-1:0] st_data_q,    st_data_d;

  logic              in_fill;
  logic              grant_d;

  // State and transaction context registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWN_I;
      issue_cnt_q  <= '0;
      rsp_cnt_q    <= '0;
      base_q       <= '0;
      st_addr_q    <= '0;
      st_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      issue_cnt_q  <= issue_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      base_q       <= base_d;
      st_addr_q    <= st_addr_d;
      st_data_q    <= st_data_d;
    end
  end

  // D wins a tie unless it owned the last transaction (round-robin on ties).
  assign grant_d = d_req && (!i_req || (last_owner_q == OWN_I));
  assign in_fill = (state_q == S_I_FILL) || (state_q == S_D_FILL);

  // Next-state, counters and all memory/fill outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    issue_cnt_d  = issue_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    base_d       = base_q;
    st_addr_d    = st_addr_q;
    st_data_d    = st_data_q;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          base_d  = d_addr & BLK_MASK;
          state_d = d_wr ? S_D_WRITE : S_D_FILL;
          if (d_wr) begin
            st_addr_d = d_addr;
            st_data_d = d_wdata;
          end
        end else if (i_req) begin
          base_d  = i_addr & BLK_MASK;
          state_d = S_I_FILL;
        end
      end

      S_I_FILL, S_D_FILL: begin
        // Issue side: one read per cycle until the whole block is requested.
        if (issue_cnt_q != ISS_ALL) begin
          mem_en      = 1'b1;
          mem_addr    = base_q + ADDR_W'({issue_cnt_q[CNT_W-1:0], 1'b0});
          issue_cnt_d = issue_cnt_q + ISS_W'(1);
        end
        // Response side: forward each returning word straight to the owner.
        if (mem_data_valid) begin
          fill_data    = mem_data;
          fill_word    = 3'(rsp_cnt_q);
          i_fill_valid = (state_q == S_I_FILL);
          d_fill_valid = (state_q == S_D_FILL);
          rsp_cnt_d    = rsp_cnt_q + CNT_W'(1);
          if (rsp_cnt_q == RSP_LAST) begin
            i_done       = (state_q == S_I_FILL);
            d_done       = (state_q == S_D_FILL);
            state_d      = S_IDLE;
            issue_cnt_d  = '0;
            rsp_cnt_d    = '0;
            last_owner_d = (state_q == S_D_FILL) ? OWN_D : OWN_I;
          end
        end
      end

      S_D_WRITE: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = st_addr_q;
        mem_wdata    = st_data_q;
        d_done       = 1'b1;
        state_d      = S_IDLE;
        last_owner_d = OWN_D;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // in_fill is kept for readability of the state grouping above.
  logic unused_ok;
  assign unused_ok = in_fill;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4-cycle pipelined memory model, directed request
// vectors, and a scoreboard monitor that pops expected memory issues, fill
// words and done pulses as the DUT presents them.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LAT    = 4;

  logic              clk;
  logic              rst_n;
  logic              i_req, d_req, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_data, fill_data;
  logic              mem_data_valid;
  logic [2:0]        fill_word;
  logic              i_fill_valid, d_fill_valid, i_done, d_done, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read issued in cycle n returns in cycle n+LAT; content is
  // a fixed function of the address. inj_* forces a stray valid.
  logic              pv [LAT];
  logic [ADDR_W-1:0] pa [LAT];
  logic              inj_valid;
  logic [DATA_W-1:0] inj_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= mem_en && !mem_wr;
      pa[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign mem_data_valid = pv[LAT-1] | inj_valid;
  assign mem_data       = inj_valid ? inj_data : (pa[LAT-1] ^ 16'h5A5A);

  // Scoreboard queues.
  typedef struct {
    int              cyc;
    logic            wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int              cyc;
    logic            is_d;
    logic [2:0]      word;
    logic [DATA_W-1:0] data;
  } fill_exp_t;

  typedef struct {
    int   cyc;
    logic is_d;
  } done_exp_t;

  mem_exp_t  exp_mem  [$];
  fill_exp_t exp_fill [$];
  done_exp_t exp_done [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A fill granted on the edge that makes cyc == c0: issue k in cycle offset k,
  // word k returns at offset k+LAT, done with the last word at offset 11.
  task automatic expect_fill(input logic is_d, input logic [ADDR_W-1:0] addr, input int c0);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      a = 16'(base + 2 * k);
      exp_mem.push_back('{c0 + k, 1'b0, a, 16'h0});
      exp_fill.push_back('{c0 + k + LAT, is_d, 3'(k), a ^ 16'h5A5A});
    end
    exp_done.push_back('{c0 + 7 + LAT, is_d});
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                              input int c0);
    exp_mem.push_back('{c0, 1'b1, addr, data});
    exp_done.push_back('{c0, 1'b1});
  endtask

  // Monitor: compares every DUT-presented event against the queue heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        if (exp_mem.size() == 0) check("mem_en_unexpected", mem_en, 0);
        else begin
          mem_exp_t e;
          e = exp_mem.pop_front();
          check("mem_cycle", cyc, e.cyc);
          check("mem_wr", mem_wr, e.wr);
          check("mem_addr", mem_addr, e.addr);
          if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (i_fill_valid || d_fill_valid) begin
        if (exp_fill.size() == 0) check("fill_unexpected", {i_fill_valid, d_fill_valid}, 0);
        else begin
          fill_exp_t f;
          f = exp_fill.pop_front();
          check("fill_cycle", cyc, f.cyc);
          check("fill_owner_id", {i_fill_valid, d_fill_valid}, f.is_d ? 2'b01 : 2'b10);
          check("fill_word", fill_word, f.word);
          check("fill_data", fill_data, f.data);
        end
      end
      if (i_done || d_done) begin
        if (exp_done.size() == 0) check("done_unexpected", {i_done, d_done}, 0);
        else begin
          done_exp_t d;
          d = exp_done.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("done_owner_id", {i_done, d_done}, d.is_d ? 2'b01 : 2'b10);
        end
      end
    end
  end

  // Wait (bounded) for the chosen done pulse, observed on a falling edge.
  task automatic wait_done(input logic is_d, input int budget);
    int   n;
    logic seen;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = is_d ? d_done : i_done;
    end while (!seen && n < budget);
    if (!seen) check(is_d ? "d_done_timeout" : "i_done_timeout", seen, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_i_done"}, i_done, 0);
    check({tag, "_d_done"}, d_done, 0);
    check({tag, "_i_fill_valid"}, i_fill_valid, 0);
    check({tag, "_d_fill_valid"}, d_fill_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; inj_valid = 1'b0; inj_data = '0;
    #1;
    check_quiet("reset");
    check("reset_mem_addr", mem_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset: D fill wins, I granted after the IDLE cycle.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h4442;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2208;
    c0 = cyc + 1;
    expect_fill(1'b1, 16'h2208, c0);
    expect_fill(1'b0, 16'h4442, c0 + 13);
    wait_done(1'b1, 40);
    @(posedge clk); #1; d_req = 1'b0;
    wait_done(1'b0, 40);
    @(posedge clk); #1; i_req = 1'b0;

    // Single-word store.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
    c0 = cyc + 1;
    expect_write(16'h1234, 16'hBEEF, c0);
    wait_done(1'b1, 10);
    @(posedge clk); #1; d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    check("store_then_idle_busy", busy, 0);

    // Tie after a D transaction: I wins, then the store.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h0A04;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0B06; d_wdata = 16'h1357;
    c0 = cyc + 1;
    expect_fill(1'b0, 16'h0A04, c0);
    expect_write(16'h0B06, 16'h1357, c0 + 13);
    wait_done(1'b0, 40);
    @(posedge clk); #1; i_req = 1'b0;
    wait_done(1'b1, 10);
    @(posedge clk); #1; d_req = 1'b0; d_wr = 1'b0;

    // Plain I fill from 0xA126 (block 0xA120..0xA12E).
    i_req = 1'b1; i_addr = 16'hA126;
    c0 = cyc + 1;
    expect_fill(1'b0, 16'hA126, c0);
    wait_done(1'b0, 40);
    @(posedge clk); #1; i_req = 1'b0;

    // Reset during the 5th issue cycle, then a clean restart.
    i_req = 1'b1; i_addr = 16'h3008;
    c0 = cyc + 1;
    expect_fill(1'b0, 16'h3008, c0);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0; i_req = 1'b0;
    #1;
    check_quiet("midfill_reset");
    exp_mem.delete(); exp_fill.delete(); exp_done.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h3008;
    c0 = cyc + 1;
    expect_fill(1'b0, 16'h3008, c0);
    wait_done(1'b0, 40);
    @(posedge clk); #1; i_req = 1'b0;

    // Stray valid while IDLE, then a fill whose request drops mid-way.
    inj_valid = 1'b1; inj_data = 16'hDEAD;
    @(negedge clk);
    check("idle_valid_i_fill", i_fill_valid, 0);
    check("idle_valid_d_fill", d_fill_valid, 0);
    @(posedge clk); #1;
    inj_valid = 1'b0;
    i_req = 1'b1; i_addr = 16'h7FF0;
    c0 = cyc + 1;
    expect_fill(1'b0, 16'h7FF0, c0);
    repeat (4) @(negedge clk);
    i_req = 1'b0;
    wait_done(1'b0, 40);
    @(negedge clk);
    check("drop_then_idle_busy", busy, 0);

    repeat (3) @(negedge clk);
    check("leftover_mem", exp_mem.size(), 0);
    check("leftover_fill", exp_fill.size(), 0);
    check("leftover_done", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
